// File: rtl/divider_param.sv
// -----------------------------------------------------------------------------
// divider_param
//   Iterative non-restoring divider for the CPU execute stage. Handles signed
//   (two's-complement) and unsigned division, flags divide-by-zero and emits a
//   one-cycle done pulse. Fixed latency of WIDTH+1 falling edges from the start
//   edge to the done edge. All state changes on the falling clock edge.
//
// Parameters
//   WIDTH        operand/result width (>= 4)
//
// Ports
//   clock        in   clock, state updates on the falling edge
//   reset_n      in   asynchronous active-low reset
//   start        in   launch (or abort-and-relaunch) an operation
//   is_signed    in   1 = signed divide, 0 = unsigned; sampled with start
//   dividend     in   WIDTH, sampled with start
//   divisor      in   WIDTH, sampled with start
//   q            out  WIDTH quotient, held until the next completion
//   r            out  WIDTH remainder, held until the next completion
//   busy         out  high from the start edge until the completing edge
//   done         out  one-cycle pulse on the completing edge
//   div_by_zero  out  set with done when the divisor was zero, held with q/r
// -----------------------------------------------------------------------------
module divider_param #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned    CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_FIXUP
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_rem;      // signed partial remainder, one guard bit
    logic [WIDTH-1:0] r_quo;      // dividend magnitude shifts out, quotient bits shift in
    logic [WIDTH-1:0] r_dvs;      // divisor magnitude
    logic [WIDTH-1:0] r_orig;     // raw dividend, returned as remainder on divide-by-zero
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_zero;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_dvs_ext;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_r_mag;
    logic [WIDTH-1:0] w_q_res;
    logic [WIDTH-1:0] w_r_res;

    // Operand magnitudes at load time
    always_comb begin
        w_dvd_neg = is_signed & dividend[WIDTH-1];
        w_dvs_neg = is_signed & divisor[WIDTH-1];
        w_dvd_mag = w_dvd_neg ? -dividend : dividend;
        w_dvs_mag = w_dvs_neg ? -divisor  : divisor;
    end

    // One non-restoring step. The WIDTH+1-bit remainder may wrap in the
    // shifted intermediate, but the post-add/sub value always lies in
    // [-D, D) and is therefore exact modulo 2^(WIDTH+1).
    always_comb begin
        w_dvs_ext = {1'b0, r_dvs};
        w_rem_sh  = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
        if (r_rem[WIDTH]) begin
            w_rem_nxt = w_rem_sh + w_dvs_ext;
        end else begin
            w_rem_nxt = w_rem_sh - w_dvs_ext;
        end
    end

    // Final correction: restore a negative remainder (result lies in [0, D),
    // so WIDTH bits suffice), then apply the latched result signs.
    always_comb begin
        w_r_mag = r_rem[WIDTH] ? (r_rem[WIDTH-1:0] + r_dvs) : r_rem[WIDTH-1:0];
        w_q_res = r_sign_q ? -r_quo   : r_quo;
        w_r_res = r_sign_r ? -w_r_mag : w_r_mag;
    end

    // Completion (FIXUP) is evaluated first and a start is applied after it,
    // so a start on the FIXUP edge both finishes the old op and loads the new
    // one, and a start during DIVIDE silently abandons the running op.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_orig      <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_zero      <= 1'b0;
            q           <= '0;
            r           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;

            case (r_state)
                ST_DIVIDE: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= {r_quo[WIDTH-2:0], ~w_rem_nxt[WIDTH]};
                    if (r_cnt == LAST_STEP) begin
                        r_state <= ST_FIXUP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FIXUP: begin
                    q           <= r_zero ? '1     : w_q_res;
                    r           <= r_zero ? r_orig : w_r_res;
                    div_by_zero <= r_zero;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (start) begin
                r_quo    <= w_dvd_mag;
                r_dvs    <= w_dvs_mag;
                r_orig   <= dividend;
                r_sign_q <= w_dvd_neg ^ w_dvs_neg;
                r_sign_r <= w_dvd_neg;
                r_zero   <= (divisor == '0);
                r_rem    <= '0;
                r_cnt    <= '0;
                busy     <= 1'b1;
                r_state  <= ST_DIVIDE;
            end
        end
    end

endmodule

// File: tb/tb_divider_param.sv
module tb_divider_param;

    logic        clock;
    logic        reset_n;

    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    logic        start8;
    logic        sgn8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [7:0]  q8;
    logic [7:0]  r8;
    logic        busy8;
    logic        done8;
    logic        z8;

    int n_checks;
    int n_errors;

    divider_param #(.WIDTH(32)) u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .q           (q),
        .r           (r),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    divider_param #(.WIDTH(8)) u_dut8 (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start8),
        .is_signed   (sgn8),
        .dividend    (a8),
        .divisor     (b8),
        .q           (q8),
        .r           (r8),
        .busy        (busy8),
        .done        (done8),
        .div_by_zero (z8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the rising edge, away from the
    // falling edge that the divider uses.
    task automatic wait_done32(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        do begin
            @(posedge clock);
            lat++;
            if (busy) bcnt++;
        end while (!done && lat < 100);
    endtask

    task automatic run32(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input logic ez);
        int lat;
        int bcnt;
        @(posedge clock);
        start = 1'b1; is_signed = sg; dividend = a; divisor = b;
        @(posedge clock);
        start = 1'b0; dividend = ~a; divisor = ~b; is_signed = ~sg;
        check_eq({tag, "_busy_start"}, 64'(busy), 64'(1));
        wait_done32(lat, bcnt);
        check_eq({tag, "_latency"}, 64'(lat), 64'(33));
        check_eq({tag, "_busy_edges"}, 64'(bcnt), 64'(33));
        check_eq({tag, "_q"}, 64'(q), 64'(eq));
        check_eq({tag, "_r"}, 64'(r), 64'(er));
        check_eq({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
        check_eq({tag, "_busy_done"}, 64'(busy), 64'(0));
        @(posedge clock);
        check_eq({tag, "_done_pulse"}, 64'(done), 64'(0));
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        do begin
            @(posedge clock);
            lat++;
        end while (!done8 && lat < 50);
    endtask

    task automatic run8(input string tag, input logic sg, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] eq,
                        input logic [7:0] er, input logic ez);
        int lat;
        @(posedge clock);
        start8 = 1'b1; sgn8 = sg; a8 = a; b8 = b;
        @(posedge clock);
        start8 = 1'b0; a8 = ~a; b8 = ~b;
        wait_done8(lat);
        check_eq({tag, "_latency"}, 64'(lat), 64'(9));
        check_eq({tag, "_q"}, 64'(q8), 64'(eq));
        check_eq({tag, "_r"}, 64'(r8), 64'(er));
        check_eq({tag, "_dbz"}, 64'(z8), 64'(ez));
    endtask

    // Reference for the 8-bit sweep, built on the native integer operators.
    function automatic void model8(input logic sg, input logic [7:0] a, input logic [7:0] b,
                                   output logic [7:0] eq, output logic [7:0] er,
                                   output logic ez);
        int          sa;
        int          sb;
        int unsigned ua;
        int unsigned ub;
        if (b == 8'd0) begin
            eq = 8'hFF; er = a; ez = 1'b1;
        end else if (sg) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            eq = 8'(sa / sb);
            er = 8'(sa % sb);
            ez = 1'b0;
        end else begin
            ua = int'(a);
            ub = int'(b);
            eq = 8'(ua / ub);
            er = 8'(ua % ub);
            ez = 1'b0;
        end
    endfunction

    initial begin
        int         lat;
        int         bcnt;
        int         ndone;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        logic [7:0] eq;
        logic [7:0] er;
        logic       ez;

        n_checks = 0;
        n_errors = 0;
        reset_n = 1'b0;
        start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;

        repeat (3) @(posedge clock);
        check_eq("rst_q", 64'(q), 64'(0));
        check_eq("rst_r", 64'(r), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_dbz", 64'(div_by_zero), 64'(0));
        check_eq("rst_busy8", 64'(busy8), 64'(0));
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        // 32-bit directed vectors
        run32("u_100_7",     1'b0, 32'd100,       32'd7,          32'd14,         32'd2,          1'b0);
        run32("s_m7_2",      1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
        run32("u_fff9_2",    1'b0, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0);
        run32("s_min_m1",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
        run32("u_max_1",     1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0);
        run32("s_100_m7",    1'b1, 32'd100,       32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0);
        run32("s_dz",        1'b1, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1);
        run32("u_dz",        1'b0, 32'h0000_1234, 32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1);

        // Abort: 100/7 restarted with 50/5 on the 10th edge
        @(posedge clock);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clock);
        start = 1'b0;
        repeat (8) @(posedge clock);
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(posedge clock);
        start = 1'b0; dividend = '0; divisor = '0;
        check_eq("abort_q_held", 64'(q), 64'hFFFF_FFFF);
        check_eq("abort_dbz_held", 64'(div_by_zero), 64'(1));
        check_eq("abort_busy", 64'(busy), 64'(1));
        wait_done32(lat, bcnt);
        check_eq("abort_latency", 64'(lat), 64'(33));
        check_eq("abort_q", 64'(q), 64'(10));
        check_eq("abort_r", 64'(r), 64'(0));
        check_eq("abort_dbz", 64'(div_by_zero), 64'(0));

        // Reset in the middle of an operation
        @(posedge clock);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clock);
        start = 1'b0;
        repeat (5) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_eq("midrst_busy", 64'(busy), 64'(0));
        check_eq("midrst_q", 64'(q), 64'(0));
        check_eq("midrst_r", 64'(r), 64'(0));
        check_eq("midrst_done", 64'(done), 64'(0));
        @(posedge clock);
        reset_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clock);
            if (done) ndone++;
        end
        check_eq("midrst_no_done", 64'(ndone), 64'(0));
        check_eq("midrst_idle", 64'(busy), 64'(0));

        // 8-bit directed vectors
        run8("w8_s_min_m1", 1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
        run8("w8_s_m100_7", 1'b1, 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0);
        run8("w8_s_100_m7", 1'b1, 8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0);
        run8("w8_s_m100_m7",1'b1, 8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0);
        run8("w8_u_156_7",  1'b0, 8'h9C, 8'h07, 8'h16, 8'h02, 1'b0);
        run8("w8_u_255_16", 1'b0, 8'hFF, 8'h10, 8'h0F, 8'h0F, 1'b0);
        run8("w8_u_5_9",    1'b0, 8'h05, 8'h09, 8'h00, 8'h05, 1'b0);
        run8("w8_s_dz",     1'b1, 8'h85, 8'h00, 8'hFF, 8'h85, 1'b1);
        run8("w8_s_127_1",  1'b1, 8'h7F, 8'h01, 8'h7F, 8'h00, 1'b0);

        // Back-to-back: 200/3 unsigned, then -9/4 signed started on the FIXUP edge
        @(posedge clock);
        start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd200; b8 = 8'd3;
        @(posedge clock);
        start8 = 1'b0;
        repeat (8) @(posedge clock);
        start8 = 1'b1; sgn8 = 1'b1; a8 = 8'hF7; b8 = 8'h04;
        @(posedge clock);
        start8 = 1'b0; a8 = '0; b8 = '0;
        check_eq("b2b_done_a", 64'(done8), 64'(1));
        check_eq("b2b_q_a", 64'(q8), 64'h42);
        check_eq("b2b_r_a", 64'(r8), 64'h02);
        check_eq("b2b_busy", 64'(busy8), 64'(1));
        wait_done8(lat);
        check_eq("b2b_latency_b", 64'(lat), 64'(9));
        check_eq("b2b_q_b", 64'(q8), 64'hFE);
        check_eq("b2b_r_b", 64'(r8), 64'hFF);

        // 8-bit sweep against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = (i % 7 == 0) ? 8'h00 : 8'($urandom);
            rs = (i % 2 == 0);
            if (i == 5) begin ra = 8'h80; rb = 8'hFF; end
            model8(rs, ra, rb, eq, er, ez);
            run8($sformatf("w8_rand%0d", i), rs, ra, rb, eq, er, ez);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
